// File: rtl/game_timer_if.sv
// Control/status bundle between the game controller and the countdown timer.
interface game_timer_if;
    logic       start;
    logic [7:0] load_val;
    logic       tick;
    logic       hold;
    logic [7:0] tcount_bits;
    logic       running;
    logic       time_up;
    logic       done;

    // Controller side: drives requests, observes count and status.
    modport master (
        output start, load_val, tick, hold,
        input  tcount_bits, running, time_up, done
    );

    // Timer side.
    modport slave (
        input  start, load_val, tick, hold,
        output tcount_bits, running, time_up, done
    );
endinterface

// File: rtl/game_timer.sv
// Loadable down-counting game timer: one decrement every TICKS_PER_STEP ticks,
// with registered running/time_up levels and a one-cycle done pulse on expiry.
module game_timer #(
    parameter int unsigned TICKS_PER_STEP = 4
) (
    input  logic         clk,
    input  logic         reset,
    game_timer_if.slave  bus
);

    localparam int unsigned PW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [PW-1:0] PrescMax = PW'(TICKS_PER_STEP - 1);

    typedef enum logic [1:0] {StIdle, StRun, StExpired} state_e;

    state_e        state_q, state_d;
    logic [7:0]    count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, running_d;
    logic          time_up_q, time_up_d;
    logic          done_q, done_d;

    // Next-state: start beats hold, hold beats tick; a tick colliding with start is dropped.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        done_d  = 1'b0;

        if (bus.start) begin
            presc_d = '0;
            if (bus.load_val != 8'd0) begin
                count_d = bus.load_val;
                state_d = StRun;
            end else begin
                count_d = 8'd0;
                state_d = StExpired;
                done_d  = 1'b1;
            end
        end else if (state_q == StRun && bus.tick && !bus.hold) begin
            if (presc_q == PrescMax) begin
                presc_d = '0;
                count_d = count_q - 8'd1;
                // RUN never holds 0, so this decrement cannot wrap.
                if (count_q == 8'd1) begin
                    state_d = StExpired;
                    done_d  = 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        running_d = (state_d == StRun);
        time_up_d = (state_d == StExpired);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= 8'd0;
            presc_q   <= '0;
            running_q <= 1'b0;
            time_up_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            time_up_q <= time_up_d;
            done_q    <= done_d;
        end
    end

    assign bus.tcount_bits = count_q;
    assign bus.running     = running_q;
    assign bus.time_up     = time_up_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed self-checking bench for game_timer (TICKS_PER_STEP = 4).
module tb_game_timer;

    logic clk = 1'b0;
    logic reset;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    game_timer_if bus ();

    game_timer #(.TICKS_PER_STEP(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are observed 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int cnt, input int run,
                           input int tup, input int dn);
        chk({tag, ".count"},   int'(bus.tcount_bits), cnt);
        chk({tag, ".running"}, int'(bus.running),     run);
        chk({tag, ".time_up"}, int'(bus.time_up),     tup);
        chk({tag, ".done"},    int'(bus.done),        dn);
    endtask

    // One tick pulse, check the edge that samples it, then two idle cycles.
    task automatic tick_chk(input string tag, input int cnt, input int dn);
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        chk({tag, ".count"}, int'(bus.tcount_bits), cnt);
        chk({tag, ".done"},  int'(bus.done),        dn);
        cyc();
        cyc();
    endtask

    task automatic do_start(input logic [7:0] val);
        bus.start    = 1'b1;
        bus.load_val = val;
        cyc();
        bus.start    = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.load_val = 8'd0;
        bus.tick     = 1'b0;
        bus.hold     = 1'b0;
        cyc();
        cyc();
        chk_all("reset", 0, 0, 0, 0);
        reset = 1'b0;

        // Reset mid-RUN with count 5.
        do_start(8'd5);
        chk_all("rst_load", 5, 1, 0, 0);
        for (int i = 0; i < 4; i++) tick_chk("rst_pre", (i == 3) ? 4 : 5, 0);
        do_start(8'd5);
        reset = 1'b1;
        cyc();
        chk_all("rst_mid1", 0, 0, 0, 0);
        cyc();
        chk_all("rst_mid2", 0, 0, 0, 0);
        reset = 1'b0;
        cyc();
        chk_all("rst_after", 0, 0, 0, 0);

        // Basic countdown from 3.
        do_start(8'd3);
        chk_all("basic_load", 3, 1, 0, 0);
        for (int i = 1; i <= 12; i++) tick_chk("basic", 3 - i / 4, (i == 12) ? 1 : 0);
        chk_all("basic_exp", 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) tick_chk("basic_extra", 0, 0);
        chk_all("basic_hold0", 0, 0, 1, 0);

        // Zero load from IDLE.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        do_start(8'd0);
        chk_all("zero1", 0, 0, 1, 1);
        cyc();
        chk_all("zero2", 0, 0, 1, 0);

        // Hold freezes prescaler.
        do_start(8'd2);
        chk_all("hold_load", 2, 1, 0, 0);
        tick_chk("hold_pre1", 2, 0);
        tick_chk("hold_pre2", 2, 0);
        bus.hold = 1'b1;
        for (int i = 0; i < 10; i++) tick_chk("hold_on", 2, 0);
        bus.hold = 1'b0;
        tick_chk("hold_post3", 2, 0);
        tick_chk("hold_post4", 1, 0);

        // Restart colliding with a tick.
        do_start(8'd5);
        for (int i = 1; i <= 6; i++) tick_chk("rs_pre", (i >= 4) ? 4 : 5, 0);
        bus.tick = 1'b1;
        do_start(8'd9);
        bus.tick = 1'b0;
        chk_all("rs_load", 9, 1, 0, 0);
        for (int i = 1; i <= 4; i++) tick_chk("rs_post", (i == 4) ? 8 : 9, 0);

        // Back-to-back starts: last wins, prescaler cleared.
        tick_chk("b2b_pre", 8, 0);
        do_start(8'd7);
        do_start(8'd6);
        chk_all("b2b", 6, 1, 0, 0);
        for (int i = 1; i <= 4; i++) tick_chk("b2b_post", (i == 4) ? 5 : 6, 0);

        // Max load.
        do_start(8'd255);
        chk_all("max_load", 255, 1, 0, 0);
        for (int i = 1; i <= 4; i++) tick_chk("max", (i == 4) ? 254 : 255, 0);

        // Expire, then re-arm from EXPIRED.
        do_start(8'd1);
        for (int i = 1; i <= 4; i++) tick_chk("arm1", (i == 4) ? 0 : 1, (i == 4) ? 1 : 0);
        chk_all("arm1_exp", 0, 0, 1, 0);
        do_start(8'd1);
        chk_all("rearm", 1, 1, 0, 0);
        for (int i = 1; i <= 4; i++) tick_chk("arm2", (i == 4) ? 0 : 1, (i == 4) ? 1 : 0);
        chk_all("arm2_exp", 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/game_timer.md
# game_timer

Loadable down-counting game timer, the countdown counterpart to the game's up-counting score counter. It sits between the tick generator and the display/game control FSM. It loads an 8-bit start value, decrements once per TICKS_PER_STEP tick pulses, and flags expiry to the control FSM. Its output bus has the same 8-bit format as the score bus, so the same display mux path can show either value.

## Interface
- TICKS_PER_STEP, 4: tick pulses per decrement (≥1); 4 gives 1 s steps from a quarter-second tick.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- start  in  1  one-cycle request: load load_val and begin counting; accepted in any state.
- load_val  in  8  start value, sampled only in a cycle where start=1.
- tick  in  1  one-cycle enable pulse (e.g. quarter-second strobe); never assumed wider than 1 cycle.
- hold  in  1  level; while 1 in RUN, ticks are ignored and the prescaler freezes.
- tcount_bits  out  8  current remaining count, registered.
- running  out  1  1 while in RUN.
- time_up  out  1  level, 1 while in EXPIRED.
- done  out  1  one-cycle pulse on entry to EXPIRED.

## Operation
- States: IDLE, RUN, EXPIRED. Internal registers are the count (8 bits) and the prescaler (ceil(log2(TICKS_PER_STEP)) bits, minimum 1).
- Reset: state IDLE, tcount_bits=0, prescaler=0, running=0, time_up=0, done=0.
- **IDLE**: tick and hold are ignored.
  - start=1 with load_val≠0: count←load_val, prescaler←0, go to RUN.
  - start=1 with load_val=0: count←0, go to EXPIRED, done pulses.
- **RUN**: on tick=1 and hold=0:
  - If prescaler=TICKS_PER_STEP−1: prescaler←0 and count←count−1.
  - If that decrement makes count 0: go to EXPIRED and pulse done.
  - Otherwise: prescaler←prescaler+1.
- **EXPIRED**: count holds at 0 and ticks are ignored. start reloads exactly as from IDLE.
- start in RUN restarts immediately: reload count and clear the prescaler. A partially accumulated step is discarded.
- Priority, highest first: reset > start > hold > tick. If start and tick arrive in the same cycle, the tick is dropped.
- Arithmetic:
  - Count is unsigned 8-bit and never wraps below 0. EXPIRED is entered at 0, so no decrement from 0 ever occurs.
  - load_val=255 is legal and gives 255 full steps.
- Outputs are registered and decoded from state:
  - running = (state==RUN).
  - time_up = (state==EXPIRED).
  - done is registered, high only on the single cycle following the transition edge.

## Timing
- start→outputs: 1 cycle. In the cycle after start is sampled, tcount_bits=load_val and running=1.
- Decrement latency: 1 cycle. tcount_bits updates on the edge at which the qualifying tick is sampled.
- Expiry: on the same edge that count becomes 0:
  - state becomes EXPIRED, so time_up=1 and running=0;
  - done=1 for exactly 1 cycle.
- Total run time from start is load_val×TICKS_PER_STEP ticks, provided hold is never asserted.
- hold takes effect in the same cycle it is sampled. When hold deasserts, counting resumes from the frozen prescaler value.
- Reset mid-RUN: next cycle shows all outputs at their reset values, and done is not pulsed.
- Back-to-back starts on consecutive cycles: the last one wins, and each start clears the prescaler.

## Test plan
- **Reset**: reset=1 for 2 cycles mid-RUN with count=5 -> tcount_bits=0, running=0, time_up=0, done=0; no done pulse.
- **Basic countdown** (TICKS_PER_STEP=4):
  - Stimulus: start with load_val=3, then 12 ticks spaced 3 cycles apart.
  - tcount_bits follows 3→2 after the 4th tick, →1 after the 8th, →0 after the 12th.
  - done pulses once on the edge of the 12th tick; time_up stays 1 afterwards.
  - Further ticks leave the count at 0.
- **Zero load**: start with load_val=0 from IDLE -> next cycle time_up=1, done=1 for 1 cycle, running never 1.
- **Hold**:
  - Stimulus: load 2; 2 ticks; hold=1 with 10 ticks; hold=0; 2 more ticks.
  - tcount_bits goes to 1 only after the 4th unheld tick.
- **Restart / collision**:
  - Stimulus: load 5; 6 ticks (count=4, prescaler=2); then start with load_val=9 and tick in the same cycle.
  - Expected: tcount_bits=9, prescaler cleared; 4 further ticks are needed to reach 8.
- **Re-arm from EXPIRED**: after expiry, start with load_val=1 -> running=1, time_up=0; after 4 ticks, done pulses again.
